// File: rtl/simple_bus_dma_copier_pkg.sv
// Shared types and constants for the word-granular bus DMA copier.
package simple_bus_dma_copier_pkg;

  // Copier FSM states; the encoding order follows the life of one transfer.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READ_CMD  = 3'd1,
    ST_READ_RSP  = 3'd2,
    ST_WRITE_CMD = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  // Every command moves a whole 32-bit word.
  localparam logic [3:0]  MASK_FULL  = 4'hF;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  // Clears the byte-offset bits so bus addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~(WORD_BYTES - 32'd1);
  endfunction

endpackage

// File: rtl/simple_bus_dma_copier.sv
// Memory-to-memory copy engine on the simple cmd/rsp bus.
// One read, then one write, per word until the count runs out or an abort is
// pending.
//
// Bus handshake: a command transfers on a cycle where cmd_valid && cmd_ready
// (fire). Once cmd_valid is high, write/address/data stay constant and valid
// stays high until fire. A read response is accepted only in READ_RSP, on the
// cycle where rsp_valid is high, and only one read is outstanding at a time.
module simple_bus_dma_copier
  import simple_bus_dma_copier_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 io_mainClk,
  input  logic                 resetCtrl_systemReset,
  input  logic                 io_ctrl_start,
  input  logic                 io_ctrl_abort,
  input  logic [31:0]          io_ctrl_srcAddress,
  input  logic [31:0]          io_ctrl_dstAddress,
  input  logic [LEN_WIDTH-1:0] io_ctrl_wordCount,
  output logic                 io_ctrl_busy,
  output logic                 io_ctrl_done,
  output logic                 io_ctrl_aborted,
  output logic [LEN_WIDTH-1:0] io_ctrl_remaining,
  output logic                 io_bus_cmd_valid,
  input  logic                 io_bus_cmd_ready,
  output logic                 io_bus_cmd_payload_write,
  output logic [31:0]          io_bus_cmd_payload_address,
  output logic [31:0]          io_bus_cmd_payload_data,
  output logic [3:0]           io_bus_cmd_payload_mask,
  input  logic                 io_bus_rsp_valid,
  input  logic [31:0]          io_bus_rsp_payload_data
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  state_t               state;
  state_t               state_next;
  logic [31:0]          src_q;
  logic [31:0]          dst_q;
  logic [31:0]          data_q;
  logic [LEN_WIDTH-1:0] remaining_q;
  logic                 abort_pend;
  logic                 cmd_fire;

  assign cmd_fire = io_bus_cmd_valid && io_bus_cmd_ready;

  // State register; reset always lands in IDLE with no completion pulse.
  always_ff @(posedge io_mainClk) begin
    if (resetCtrl_systemReset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a pending abort never cuts a presented command short.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (io_ctrl_start) begin
          state_next = (io_ctrl_wordCount == '0) ? ST_DONE : ST_READ_CMD;
        end
      end
      ST_READ_CMD: begin
        if (cmd_fire) state_next = ST_READ_RSP;
      end
      ST_READ_RSP: begin
        if (io_bus_rsp_valid) state_next = abort_pend ? ST_DONE : ST_WRITE_CMD;
      end
      ST_WRITE_CMD: begin
        if (cmd_fire) begin
          state_next = (remaining_q == LEN_ONE || abort_pend) ? ST_DONE : ST_READ_CMD;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Address, count and data registers.
  always_ff @(posedge io_mainClk) begin
    if (resetCtrl_systemReset) begin
      src_q       <= '0;
      dst_q       <= '0;
      data_q      <= '0;
      remaining_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (io_ctrl_start) begin
            src_q       <= word_align(io_ctrl_srcAddress);
            dst_q       <= word_align(io_ctrl_dstAddress);
            remaining_q <= io_ctrl_wordCount;
          end
        end
        ST_READ_RSP: begin
          if (io_bus_rsp_valid) data_q <= io_bus_rsp_payload_data;
        end
        ST_WRITE_CMD: begin
          if (cmd_fire) begin
            src_q       <= src_q + WORD_BYTES;
            dst_q       <= dst_q + WORD_BYTES;
            remaining_q <= remaining_q - LEN_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Sticky abort request: armed while busy, consumed by the DONE cycle.
  always_ff @(posedge io_mainClk) begin
    if (resetCtrl_systemReset) begin
      abort_pend <= 1'b0;
    end else if (state == ST_DONE) begin
      abort_pend <= 1'b0;
    end else if (state != ST_IDLE && io_ctrl_abort) begin
      abort_pend <= 1'b1;
    end
  end

  // Bus and status outputs are pure decodes of registered state.
  always_comb begin
    io_bus_cmd_valid           = 1'b0;
    io_bus_cmd_payload_write   = 1'b0;
    io_bus_cmd_payload_address = '0;
    io_bus_cmd_payload_data    = '0;
    io_bus_cmd_payload_mask    = MASK_FULL;
    case (state)
      ST_READ_CMD: begin
        io_bus_cmd_valid           = 1'b1;
        io_bus_cmd_payload_address = src_q;
      end
      ST_WRITE_CMD: begin
        io_bus_cmd_valid           = 1'b1;
        io_bus_cmd_payload_write   = 1'b1;
        io_bus_cmd_payload_address = dst_q;
        io_bus_cmd_payload_data    = data_q;
      end
      default: begin
      end
    endcase
  end

  assign io_ctrl_busy      = (state != ST_IDLE);
  assign io_ctrl_done      = (state == ST_DONE);
  assign io_ctrl_aborted   = (state == ST_DONE) && abort_pend;
  assign io_ctrl_remaining = remaining_q;

endmodule
